// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer driving the single-bus CPU datapath through fetch and execute.
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes into S_HALT with a sticky `illegal` output.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        mem_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_HALT, C_RTYPE, C_ADDI, C_LDI, C_LD, C_ST, C_ILLEGAL
  } iclass_t;

  // The counter only has to hold 0 .. MEM_TIMEOUT-1 stalled cycles.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t           state_q, state_d;
  iclass_t          iclass;
  logic [4:0]       opcode;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_state, stall, timeout;
  logic             unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  always_comb begin
    iclass = C_NOP;
    case (opcode)
      OP_LD:                       iclass = C_LD;
      OP_LDI:                      iclass = C_LDI;
      OP_ST:                       iclass = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: iclass = C_RTYPE;
      OP_ADDI:                     iclass = C_ADDI;
      OP_NOP:                      iclass = C_NOP;
      OP_HALT:                     iclass = C_HALT;
`ifdef ILLEGAL_TRAP_EN
      default:                     iclass = C_ILLEGAL;
`else
      default:                     iclass = C_NOP;
`endif
    endcase
  end

  // Only the fetch read, the ld data read and the st write wait on memory.
  assign wait_state = (state_q == T1)
                   || (state_q == T6 && iclass == C_LD)
                   || (state_q == T7 && iclass == C_ST);
  assign stall      = wait_state && !mem_ready;
  assign timeout    = TIMEOUT_EN && stall && (wait_cnt == CNT_LIMIT);

`ifdef ILLEGAL_TRAP_EN
  logic trap;
  assign trap = (state_q == T2) && (iclass == C_ILLEGAL);
`endif

  // NOTE: state is only a handful of flops, so every one of them is reset; nothing here is a memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_RST;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      wait_cnt <= stall ? wait_cnt + CNT_W'(1) : '0;
      if (timeout) mem_err <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (trap) illegal <= 1'b1;
`endif
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    alu_op  = 5'b00000;
    run     = (state_q != S_HALT);

    case (state_q)
      S_RST: state_d = T0;

      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = T1;
      end

      T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        PCin    = mem_ready;
        MDRin   = mem_ready;
        if (mem_ready)    state_d = T2;
        else if (timeout) state_d = S_HALT;
      end

      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        case (iclass)
          C_NOP:             state_d = T0;
          C_HALT, C_ILLEGAL: state_d = S_HALT;
          default:           state_d = T3;
        endcase
      end

      T3: begin
        Grb     = 1'b1;
        Yin     = 1'b1;
        state_d = T4;
        // Immediate forms add to the base register (BAout forces R0 to read as zero).
        if (iclass == C_LDI || iclass == C_LD || iclass == C_ST) BAout = 1'b1;
        else                                                    Rout  = 1'b1;
      end

      T4: begin
        Zin     = 1'b1;
        state_d = T5;
        if (iclass == C_RTYPE) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          alu_op = opcode;
        end else begin
          Cout   = 1'b1;
          alu_op = OP_ADD;
        end
      end

      T5: begin
        Zlowout = 1'b1;
        if (iclass == C_LD || iclass == C_ST) begin
          MARin   = 1'b1;
          state_d = T6;
        end else begin
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = T0;
        end
      end

      T6: begin
        if (iclass == C_LD) begin
          Read  = 1'b1;
          MDRin = 1'b1;
          if (mem_ready)    state_d = T7;
          else if (timeout) state_d = S_HALT;
        end else if (iclass == C_ST) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          MDRin   = 1'b1;
          state_d = T7;
        end else begin
          state_d = T0;
        end
      end

      T7: begin
        if (iclass == C_LD) begin
          MDRout  = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = T0;
        end else if (iclass == C_ST) begin
          Write = 1'b1;
          if (mem_ready)    state_d = T0;
          else if (timeout) state_d = S_HALT;
        end else begin
          state_d = T0;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a per-instruction T-state table model queues
// stimulus and expected strobes; a driver and a monitor consume the two queues independently.
module tb_control_sequencer;

  localparam int TMO = 4;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [18:0] PCOUT   = 19'h40000;
  localparam logic [18:0] PCIN    = 19'h20000;
  localparam logic [18:0] INCPC   = 19'h10000;
  localparam logic [18:0] MARIN   = 19'h08000;
  localparam logic [18:0] MDRIN   = 19'h04000;
  localparam logic [18:0] MDROUT  = 19'h02000;
  localparam logic [18:0] IRIN    = 19'h01000;
  localparam logic [18:0] YIN     = 19'h00800;
  localparam logic [18:0] ZIN     = 19'h00400;
  localparam logic [18:0] ZLOWOUT = 19'h00200;
  localparam logic [18:0] COUT    = 19'h00100;
  localparam logic [18:0] READ    = 19'h00080;
  localparam logic [18:0] WRITE   = 19'h00040;
  localparam logic [18:0] GRA     = 19'h00020;
  localparam logic [18:0] GRB     = 19'h00010;
  localparam logic [18:0] GRC     = 19'h00008;
  localparam logic [18:0] RIN     = 19'h00004;
  localparam logic [18:0] ROUT    = 19'h00002;
  localparam logic [18:0] BAOUT   = 19'h00001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_op;
  logic        run, mem_err, illegal;
  logic [18:0] strobes;

`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  control_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .alu_op(alu_op), .run(run), .mem_err(mem_err)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  assign strobes = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
                    Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          mr;
    logic [31:0] irv;
  } stim_t;

  typedef struct {
    logic [18:0] s;
    logic [4:0]  alu;
    bit          run;
    bit          err;
    bit          ill;
    string       tag;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          cur_err = 1'b0;
  bit          cur_ill = 1'b0;
  logic [31:0] cur_ir = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock cycle of stimulus plus the response the model expects in that cycle.
  task automatic cyc(input bit rst, input bit mr, input logic [18:0] s, input logic [4:0] alu,
                     input bit r, input string tag);
    stim_t st;
    exp_t  e;
    st.rst = rst; st.mr = mr; st.irv = cur_ir;
    e.s = s; e.alu = alu; e.run = r; e.err = cur_err; e.ill = cur_ill; e.tag = tag;
    stim_q.push_back(st);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    cur_err = 1'b0;
    cur_ill = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b1, rnd(), '0, '0, 1'b1, "reset");
    cyc(1'b0, rnd(), '0, '0, 1'b1, "s_rst");
  endtask

  task automatic halted(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rnd(), '0, '0, 1'b0, "halt");
  endtask

  // A memory wait: `stalls` cycles with mem_ready low, then one with it high, unless the limit expires.
  task automatic wait_phase(input logic [18:0] st, input logic [18:0] dn, input int stalls,
                            input string tag, output bit tmo);
    tmo = 1'b0;
    if (stalls >= TMO) begin
      for (int i = 0; i < TMO; i++) cyc(1'b0, 1'b0, st, '0, 1'b1, tag);
      cur_err = 1'b1;
      tmo     = 1'b1;
    end else begin
      for (int i = 0; i < stalls; i++) cyc(1'b0, 1'b0, st, '0, 1'b1, tag);
      cyc(1'b0, 1'b1, dn, '0, 1'b1, tag);
    end
  endtask

  task automatic instr(input logic [31:0] v, input int s1, input int s2, output bit stopped);
    logic [4:0] op;
    bit         tmo;
    op      = v[31:27];
    cur_ir  = v;
    stopped = 1'b0;
    cyc(1'b0, rnd(), PCOUT | MARIN | INCPC | ZIN, '0, 1'b1, "T0");
    wait_phase(ZLOWOUT | READ, ZLOWOUT | PCIN | READ | MDRIN, s1, "T1", tmo);
    if (tmo) begin
      stopped = 1'b1;
      return;
    end
    cyc(1'b0, rnd(), MDROUT | IRIN, '0, 1'b1, "T2");
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        cyc(1'b0, rnd(), GRB | ROUT | YIN, '0, 1'b1, "rtype_T3");
        cyc(1'b0, rnd(), GRC | ROUT | ZIN, op, 1'b1, "rtype_T4");
        cyc(1'b0, rnd(), ZLOWOUT | GRA | RIN, '0, 1'b1, "rtype_T5");
      end
      OP_ADDI: begin
        cyc(1'b0, rnd(), GRB | ROUT | YIN, '0, 1'b1, "addi_T3");
        cyc(1'b0, rnd(), COUT | ZIN, OP_ADD, 1'b1, "addi_T4");
        cyc(1'b0, rnd(), ZLOWOUT | GRA | RIN, '0, 1'b1, "addi_T5");
      end
      OP_LDI: begin
        cyc(1'b0, rnd(), GRB | BAOUT | YIN, '0, 1'b1, "ldi_T3");
        cyc(1'b0, rnd(), COUT | ZIN, OP_ADD, 1'b1, "ldi_T4");
        cyc(1'b0, rnd(), ZLOWOUT | GRA | RIN, '0, 1'b1, "ldi_T5");
      end
      OP_LD: begin
        cyc(1'b0, rnd(), GRB | BAOUT | YIN, '0, 1'b1, "ld_T3");
        cyc(1'b0, rnd(), COUT | ZIN, OP_ADD, 1'b1, "ld_T4");
        cyc(1'b0, rnd(), ZLOWOUT | MARIN, '0, 1'b1, "ld_T5");
        wait_phase(READ | MDRIN, READ | MDRIN, s2, "ld_T6", tmo);
        if (tmo) stopped = 1'b1;
        else     cyc(1'b0, rnd(), MDROUT | GRA | RIN, '0, 1'b1, "ld_T7");
      end
      OP_ST: begin
        cyc(1'b0, rnd(), GRB | BAOUT | YIN, '0, 1'b1, "st_T3");
        cyc(1'b0, rnd(), COUT | ZIN, OP_ADD, 1'b1, "st_T4");
        cyc(1'b0, rnd(), ZLOWOUT | MARIN, '0, 1'b1, "st_T5");
        cyc(1'b0, rnd(), GRA | ROUT | MDRIN, '0, 1'b1, "st_T6");
        wait_phase(WRITE, WRITE, s2, "st_T7", tmo);
        if (tmo) stopped = 1'b1;
      end
      OP_HALT: stopped = 1'b1;
      OP_NOP: ;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        cur_ill = 1'b1;
        stopped = 1'b1;
`endif
      end
    endcase
  endtask

  task automatic build();
    logic [4:0]  ops[12] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                             OP_NOP, OP_HALT, 5'b11111, 5'b01000};
    logic [31:0] r;
    bit          stop;
    int          s1, s2, k;

    do_reset(2);
    instr(32'h18918000, 0, 0, stop);                    // add R1,R2,R3
    instr(32'h02000010, 0, 3, stop);                    // ld R4,0x10(R0), 3 stalls in T6
    instr(32'h10800020, 1, 2, stop);                    // st, 2 stalls in T7
    instr(32'h18918000, 6, 0, stop);                    // fetch never answered: timeout
    halted(3);
    do_reset(1);
    instr(32'h18918000, TMO - 1, 0, stop);              // ready arrives on the limit cycle
    instr(32'h0A000005, 0, 0, stop);                    // ldi
    instr(32'h61000007, 0, 0, stop);                    // addi
    instr(32'h21918000, 0, 0, stop);                    // sub
    instr(32'h29918000, 0, 0, stop);                    // and
    instr(32'h31918000, 0, 0, stop);                    // or
    instr(32'h02000010, 0, 5, stop);                    // ld data read times out
    halted(2);
    do_reset(1);
    instr(32'hD0000000, 0, 0, stop);                    // nop
    instr(32'hD8000000, 0, 0, stop);                    // halt
    halted(20);
    do_reset(1);
    instr(32'hF8000000, 0, 0, stop);                    // unknown opcode
    if (stop) begin
      halted(3);
      do_reset(1);
    end

    for (int n = 0; n < 250; n++) begin
      r  = $urandom();
      s1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO, TMO + 2)) : int'($urandom_range(0, TMO - 1));
      s2 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO, TMO + 2)) : int'($urandom_range(0, TMO - 1));
      instr({ops[$urandom_range(0, 11)], r[26:0]}, s1, s2, stop);
      if (stop) begin
        halted(int'($urandom_range(1, 5)));
        do_reset(int'($urandom_range(1, 2)));
      end else if ($urandom_range(0, 19) == 0) begin
        // Abort the instruction part-way: drop its tail and assert reset instead.
        k = int'($urandom_range(1, 2));
        for (int i = 0; i < k; i++) begin
          void'(stim_q.pop_back());
          void'(exp_q.pop_back());
        end
        do_reset(1);
      end
    end
  endtask

  task automatic drive();
    stim_t st;
    while (stim_q.size() > 0) begin
      @(negedge clock);
      st        = stim_q.pop_front();
      reset     = st.rst;
      mem_ready = st.mr;
      ir        = st.irv;
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      #2;
      e = exp_q.pop_front();
      check($sformatf("%s@%0d strobes/alu", e.tag, n),
            {8'h00, strobes, alu_op}, {8'h00, e.s, e.alu});
      check($sformatf("%s@%0d run/mem_err/illegal", e.tag, n),
            {29'h0, run, mem_err, illegal}, {29'h0, e.run, e.err, e.ill});
      n++;
    end
  endtask

  initial begin
    build();
    fork
      drive();
      monitor();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
